// File: rtl/out_window_pkg.sv
// Shared constants and the nibble-to-digit-code helper for the digest display window.
// Digit code: bit4 set means blank, otherwise bits3:0 carry the hex value.
package out_window_pkg;

  localparam logic [4:0] SEG_BLANK  = 5'b10000;
  localparam int         NIBBLES    = 32;
  localparam int         WIN_DIGITS = 6;
  localparam logic [3:0] PTR_MAX    = 4'd13;

  function automatic logic [4:0] seg_code(input logic [127:0] val,
                                          input logic [4:0]   idx,
                                          input logic         vld);
    logic [6:0] bit_base;
    bit_base = {idx, 2'b00};
    return vld ? {1'b0, val[bit_base +: 4]} : SEG_BLANK;
  endfunction

endpackage

// File: rtl/out_window_btn_edge.sv
// Rising-edge detector: fire is combinational from the input and the previous-sample flop,
// so a press sampled at edge k acts at edge k.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_fire
);

  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= i_btn;
  end

  assign o_fire = i_btn & ~r_prev;

endmodule

// File: rtl/out_window.sv
// Captures a 128-bit digest and shows a six-nibble window; buttons scroll it a byte at a time.
// Outputs are combinational from registers; start=1 freezes state but edges are still tracked.
module out_window
  import out_window_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic         capture,
  input  logic         left_shift,
  input  logic         right_shift,
  input  logic         start,
  output logic [4:0]   seg,
  output logic [4:0]   seg1,
  output logic [4:0]   seg2,
  output logic [4:0]   seg3,
  output logic [4:0]   seg4,
  output logic [4:0]   seg5
);

  logic [127:0] r_cap;
  logic         r_valid;
  logic [3:0]   r_ptr;
  logic         w_cap_fire;
  logic         w_left_fire;
  logic         w_right_fire;
  logic [4:0]   w_seg [WIN_DIGITS];

  btn_edge u_cap_edge   (.i_clk(clk), .i_rst_n(rst), .i_btn(capture),     .o_fire(w_cap_fire));
  btn_edge u_left_edge  (.i_clk(clk), .i_rst_n(rst), .i_btn(left_shift),  .o_fire(w_left_fire));
  btn_edge u_right_edge (.i_clk(clk), .i_rst_n(rst), .i_btn(right_shift), .o_fire(w_right_fire));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (!start) begin
      if (w_cap_fire) begin
        r_cap   <= data_in;
        r_valid <= 1'b1;
      end
      // Simultaneous left+right cancel out; both directions saturate.
      if (w_left_fire && !w_right_fire && r_ptr != PTR_MAX)
        r_ptr <= r_ptr + 4'd1;
      else if (w_right_fire && !w_left_fire && r_ptr != 4'd0)
        r_ptr <= r_ptr - 4'd1;
    end
  end

  always_comb begin
    for (int n = 0; n < WIN_DIGITS; n++)
      w_seg[n] = seg_code(r_cap, {r_ptr, 1'b0} + 5'(n), r_valid);
  end

  assign seg  = w_seg[0];
  assign seg1 = w_seg[1];
  assign seg2 = w_seg[2];
  assign seg3 = w_seg[3];
  assign seg4 = w_seg[4];
  assign seg5 = w_seg[5];

endmodule

// File: tb/tb_out_window.sv
// Self-checking bench for out_window: directed scenarios plus randomized presses
// compared against a behavioural model of the window position and captured value.
module tb_out_window;

  localparam logic [127:0] TEST_DATA = 128'h14240000650011001100220033664400;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] data_in = '0;
  logic         capture = 1'b0;
  logic         left_shift = 1'b0;
  logic         right_shift = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   seg, seg1, seg2, seg3, seg4, seg5;

  int checks = 0;
  int failures = 0;

  // Behavioural model: window position, captured value, display enable, last driven levels.
  logic [127:0] m_cap;
  bit           m_valid;
  int           m_ptr;
  bit           m_pc, m_pl, m_pr;

  out_window dut (
    .clk(clk), .rst(rst), .data_in(data_in), .capture(capture),
    .left_shift(left_shift), .right_shift(right_shift), .start(start),
    .seg(seg), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] got_disp();
    return {seg5, seg4, seg3, seg2, seg1, seg};
  endfunction

  function automatic logic [29:0] exp_disp();
    logic [29:0] r;
    logic [127:0] sh;
    r = '0;
    for (int n = 0; n < 6; n++) begin
      sh = m_cap >> (8 * m_ptr + 4 * n);
      r[5*n +: 5] = m_valid ? {1'b0, sh[3:0]} : 5'b10000;
    end
    return r;
  endfunction

  // Six hex digits listed seg5 first, packed into the expected display word.
  function automatic logic [29:0] digits(input int d5, input int d4, input int d3,
                                         input int d2, input int d1, input int d0);
    return {1'b0, 4'(d5), 1'b0, 4'(d4), 1'b0, 4'(d3), 1'b0, 4'(d2), 1'b0, 4'(d1), 1'b0, 4'(d0)};
  endfunction

  task automatic model_reset();
    m_cap = '0; m_valid = 0; m_ptr = 0; m_pc = 0; m_pl = 0; m_pr = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the press rules, land 1 time unit after the edge.
  task automatic step(input bit c, input bit l, input bit r, input bit s);
    bit fc, fl, fr;
    capture = c; left_shift = l; right_shift = r; start = s;
    fc = c && !m_pc; fl = l && !m_pl; fr = r && !m_pr;
    if (!s) begin
      if (fc) begin m_cap = data_in; m_valid = 1; end
      if (fl && !fr) m_ptr = (m_ptr >= 13) ? 13 : m_ptr + 1;
      if (fr && !fl) m_ptr = (m_ptr <= 0) ? 0 : m_ptr - 1;
    end
    m_pc = c; m_pl = l; m_pr = r;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit c, input bit l, input bit r);
    step(c, l, r, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; model_reset();
    #2;
    checks++;
    if (got_disp() !== {6{5'b10000}}) begin
      failures++; $display("FAIL reset_hold got=%h exp=%h", got_disp(), {6{5'b10000}});
    end
    @(posedge clk); #3 rst = 1'b1;
    repeat (3) step(0, 0, 0, 0);
    checks++;
    if (got_disp() !== {6{5'b10000}}) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", got_disp(), {6{5'b10000}});
    end
  endtask

  task automatic test_scroll();
    data_in = TEST_DATA;
    press(0, 1, 0); press(0, 1, 0); press(1, 0, 0);
    checks++;
    if (seg !== 5'b00110) begin
      failures++; $display("FAIL scroll_ptr2 got=%h exp=%h", seg, 5'b00110);
    end
    for (int i = 0; i < 3; i++) begin press(0, 1, 0); press(1, 0, 0); end
    press(0, 0, 1); press(0, 0, 1);
    checks++;
    if (got_disp() !== digits(2, 2, 0, 0, 3, 3)) begin
      failures++; $display("FAIL scroll_ptr3 got=%h exp=%h", got_disp(), digits(2, 2, 0, 0, 3, 3));
    end
    checks++;
    if (got_disp() !== exp_disp()) begin
      failures++; $display("FAIL scroll_model got=%h exp=%h", got_disp(), exp_disp());
    end
  endtask

  task automatic test_start_lock();
    data_in = ~TEST_DATA;
    step(0, 1, 0, 1); step(0, 0, 0, 1);
    step(1, 0, 0, 1); step(0, 0, 0, 1);
    checks++;
    if (seg !== 5'b00011 || got_disp() !== digits(2, 2, 0, 0, 3, 3)) begin
      failures++; $display("FAIL start_lock got=%h exp=%h", got_disp(), digits(2, 2, 0, 0, 3, 3));
    end
    // A press whose rising edge falls inside start=1 must not act after start drops.
    step(1, 1, 0, 1); step(1, 1, 0, 0); step(0, 0, 0, 0);
    checks++;
    if (got_disp() !== digits(2, 2, 0, 0, 3, 3)) begin
      failures++; $display("FAIL start_lost_edge got=%h exp=%h", got_disp(), digits(2, 2, 0, 0, 3, 3));
    end
    data_in = TEST_DATA;
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b0; model_reset();
    #1;
    checks++;
    if (got_disp() !== {6{5'b10000}}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", got_disp(), {6{5'b10000}});
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    press(1, 0, 0);
    checks++;
    if (got_disp() !== digits(6, 6, 4, 4, 0, 0)) begin
      failures++; $display("FAIL reset_recapture got=%h exp=%h", got_disp(), digits(6, 6, 4, 4, 0, 0));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) press(0, 1, 0);
    press(1, 0, 0);
    checks++;
    if (got_disp() !== digits(1, 4, 2, 4, 0, 0)) begin
      failures++; $display("FAIL sat_high got=%h exp=%h", got_disp(), digits(1, 4, 2, 4, 0, 0));
    end
    press(0, 1, 0); press(0, 1, 0);
    checks++;
    if (got_disp() !== digits(1, 4, 2, 4, 0, 0)) begin
      failures++; $display("FAIL sat_more_left got=%h exp=%h", got_disp(), digits(1, 4, 2, 4, 0, 0));
    end
    press(0, 1, 1);
    checks++;
    if (got_disp() !== digits(1, 4, 2, 4, 0, 0)) begin
      failures++; $display("FAIL left_right_conflict got=%h exp=%h", got_disp(), digits(1, 4, 2, 4, 0, 0));
    end
    for (int i = 0; i < 16; i++) press(0, 0, 1);
    checks++;
    if (got_disp() !== digits(6, 6, 4, 4, 0, 0)) begin
      failures++; $display("FAIL sat_low got=%h exp=%h", got_disp(), digits(6, 6, 4, 4, 0, 0));
    end
    press(0, 1, 0); press(0, 1, 1);
    checks++;
    if (got_disp() !== digits(3, 3, 6, 6, 4, 4)) begin
      failures++; $display("FAIL conflict_mid got=%h exp=%h", got_disp(), digits(3, 3, 6, 6, 4, 4));
    end
  endtask

  task automatic test_back_to_back();
    // Holding a button produces one move; alternating 1/0 produces one move per high.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    checks++;
    if (got_disp() !== digits(0, 0, 3, 3, 6, 6)) begin
      failures++; $display("FAIL held_button got=%h exp=%h", got_disp(), digits(0, 0, 3, 3, 6, 6));
    end
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(1, 0, 0, 0);
    checks++;
    if (got_disp() !== exp_disp() || m_ptr != 4) begin
      failures++; $display("FAIL back_to_back got=%h exp=%h", got_disp(), exp_disp());
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) data_in = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      checks++;
      if (got_disp() !== exp_disp()) begin
        failures++; $display("FAIL random_%0d got=%h exp=%h ptr=%0d", i, got_disp(), exp_disp(), m_ptr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_start_lock();
    test_async_reset();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
